// File: rtl/memarb_if.sv
// memarb bus bundle: fetch requester, data requester and the shared memory port.
// The arbiter side uses modport master; requesters plus memory use modport slave.
interface memarb_if #(
  parameter int n = 16
);
  // Instruction-fetch requester
  logic         if_req;
  logic [n-1:0] if_addr;
  logic         if_ack;
  logic [n-1:0] if_rdata;

  // Load/store requester
  logic         d_req;
  logic         d_we;
  logic [n-1:0] d_addr;
  logic [n-1:0] d_wdata;
  logic         d_ack;
  logic [n-1:0] d_rdata;

  // Unified memory port
  logic         m_req;
  logic         m_we;
  logic [n-1:0] m_addr;
  logic [n-1:0] m_wdata;
  logic [n-1:0] m_rdata;
  logic         m_ready;

  // Status
  logic         busy;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_ack, if_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/memarb.sv
// memarb: single-port memory arbiter/sequencer shared by instruction fetch and
// load/store. One transaction at a time: IDLE -> BUSY_x -> RESP -> IDLE.
// Contended grants alternate using last_d so neither side can starve.
// Every output is a flop or a pure decode of state, so no input reaches an
// output combinationally.
module memarb #(
  parameter int n = 16
) (
  input logic      clk,
  input logic      reset,   // asynchronous, active low
  memarb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         last_d_q, last_d_d;      // 1 = most recent grant went to data
  logic [n-1:0] addr_q, addr_d;          // latched request, frozen while busy
  logic         we_q, we_d;
  logic [n-1:0] wdata_q, wdata_d;
  logic [n-1:0] if_rdata_q, if_rdata_d;
  logic [n-1:0] d_rdata_q, d_rdata_d;

  // Next-state logic: arbitration in IDLE, wait for m_ready in BUSY, one-cycle ack in RESP
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        // Data wins when alone, or when contended and fetch had the last grant.
        if (bus.d_req && (!bus.if_req || !last_d_q)) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
          addr_d   = bus.d_addr;
          we_d     = bus.d_we;
          wdata_d  = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
        end
      end
      BUSY_I: begin
        if (bus.m_ready) begin
          if_rdata_d = bus.m_rdata;
          state_d    = RESP;
        end
      end
      BUSY_D: begin
        if (bus.m_ready) begin
          // A store leaves the previously loaded value in place.
          if (!we_q) begin
            d_rdata_d = bus.m_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Outputs: state decodes and latched registers only. In RESP, last_d_q
  // names the port that was just served.
  assign bus.m_req    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign bus.m_we     = bus.m_req && we_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.if_ack   = (state_q == RESP) && !last_d_q;
  assign bus.d_ack    = (state_q == RESP) && last_d_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_memarb.sv
// Testbench for memarb: directed vector table, hand sequences for arbitration,
// reset abort and spurious ready, then random traffic against a
// transaction-level reference model.
module tb_memarb;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memarb_if #(.n(N)) bus ();
  memarb #(.n(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Memory responder state
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  int wait_cfg = 0;
  int wcnt = 0;
  int spur = 0;    // 0: m_ready low when idle, 1: random, 2: always high

  // Expected register contents for directed tests
  logic [15:0] cur_if, cur_d;

  typedef struct {
    bit          fetch;
    bit          we;
    bit          preload;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] memval;
    int          waits;
    logic [15:0] exp_if;
    logic [15:0] exp_d;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: commit a completing store, advance, then drive the memory side.
  task automatic cyc();
    if (bus.m_req === 1'b1 && bus.m_ready === 1'b1 && bus.m_we === 1'b1)
      mem[bus.m_addr[7:0]] = bus.m_wdata;
    @(posedge clk);
    #1;
    if (bus.m_req === 1'b1) begin
      if (wcnt >= wait_cfg) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = mem[bus.m_addr[7:0]];
      end else begin
        bus.m_ready = 1'b0;
        bus.m_rdata = 16'($urandom);
      end
      wcnt++;
    end else begin
      wcnt = 0;
      bus.m_ready = (spur == 2) ? 1'b1 : ((spur == 1) ? 1'($urandom) : 1'b0);
      bus.m_rdata = 16'($urandom);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  // Single transaction on an otherwise idle arbiter, checked against the vector.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int mq;
    n = 0;
    mq = 0;
    if (v.preload) mem[v.addr[7:0]] = v.memval;
    wait_cfg = v.waits;
    if (v.fetch) begin
      bus.if_req = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.d_req = 1'b1;
      bus.d_we = v.we;
      bus.d_addr = v.addr;
      bus.d_wdata = v.wdata;
    end
    while (n < 40) begin
      cyc();
      n++;
      if (bus.m_req === 1'b1) begin
        mq++;
        chk({tag, "_m_addr"}, bus.m_addr, v.addr);
        chk({tag, "_m_we"}, bus.m_we, v.we);
        if (v.we) chk({tag, "_m_wdata"}, bus.m_wdata, v.wdata);
      end
      if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) break;
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, "_latency"}, n, v.waits + 2);
    chk({tag, "_mreq_cycles"}, mq, v.waits + 1);
    chk({tag, "_if_ack"}, bus.if_ack, v.fetch);
    chk({tag, "_d_ack"}, bus.d_ack, !v.fetch);
    chk({tag, "_if_rdata"}, bus.if_rdata, v.exp_if);
    chk({tag, "_d_rdata"}, bus.d_rdata, v.exp_d);
    $display("txn %s: %s addr=0x%04h we=%0d waits=%0d if_rdata=0x%04h d_rdata=0x%04h",
             tag, v.fetch ? "fetch" : "data", v.addr, v.we, v.waits, bus.if_rdata, bus.d_rdata);
    cyc();
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_ack_once"}, {bus.if_ack, bus.d_ack}, 0);
    chk({tag, "_mem"}, mem[v.addr[7:0]], v.exp_mem);
    cur_if = v.exp_if;
    cur_d = v.exp_d;
  endtask

  // Random-phase model state
  logic        pf, pd, ack_now, last_d, in_txn, g_d, g_we;
  logic [15:0] g_addr, g_wdata, exp_if, exp_d;
  int          mreq_cnt, txn_wait, stall, ntx;
  vec_t        v;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'h1234, 0, 16'h1234, 16'h0000, 16'h1234};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 2, 16'h1234, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 16'h00AA, 0, 16'h1234, 16'h00AA, 16'h00AA};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555, 16'h0000, 1, 16'h1234, 16'h00AA, 16'h5555};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 0, 16'h5555, 16'h00AA, 16'h5555};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA5A5, 3, 16'hA5A5, 16'h00AA, 16'hA5A5};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 16'h1111, 0, 16'hA5A5, 16'h00AA, 16'hFFFF};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1, 16'hA5A5, 16'hFFFF, 16'hFFFF};

    // Reset state
    cyc(); cyc();
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    reset = 1'b1;
    cyc();

    // Directed vector table
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Spurious m_ready while idle and in RESP
    spur = 2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("spur_idle_busy", bus.busy, 0);
      chk("spur_idle_ack", {bus.if_ack, bus.d_ack}, 0);
      chk("spur_idle_if_rdata", bus.if_rdata, cur_if);
      chk("spur_idle_d_rdata", bus.d_rdata, cur_d);
    end
    v = '{1'b1, 1'b0, 1'b1, 16'h0008, 16'h0000, 16'h3C3C, 1, 16'h3C3C, 16'hFFFF, 16'h3C3C};
    run_txn(v, "spur_fetch");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("spur_post_busy", bus.busy, 0);
      chk("spur_post_if_rdata", bus.if_rdata, 16'h3C3C);
      chk("spur_post_d_rdata", bus.d_rdata, 16'hFFFF);
    end
    spur = 0;

    // Both requesters held: grants must alternate data, fetch, data, fetch
    reset_dut();
    mem[8'h40] = 16'h1111;
    mem[8'h50] = 16'h2222;
    wait_cfg = 0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0050;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (n < 12) begin
        cyc();
        n++;
        if (bus.m_req === 1'b1)
          chk("both_m_addr", bus.m_addr, (k % 2 == 0) ? 16'h0050 : 16'h0040);
        if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) break;
      end
      chk("both_latency", n, (k == 0) ? 2 : 3);
      chk("both_ack_excl", bus.if_ack & bus.d_ack, 0);
      chk("both_grant_port", bus.d_ack, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) chk("both_d_rdata", bus.d_rdata, 16'h2222);
      else            chk("both_if_rdata", bus.if_rdata, 16'h1111);
      $display("txn both%0d: grant=%s if_rdata=0x%04h d_rdata=0x%04h",
               k, bus.d_ack ? "data" : "fetch", bus.if_rdata, bus.d_rdata);
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    cyc();
    chk("both_end_ack", {bus.if_ack, bus.d_ack}, 0);

    // Reset asserted between edges during a store
    mem[8'h60] = 16'h0BAD;
    wait_cfg = 5;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0060; bus.d_wdata = 16'h1234;
    cyc();
    chk("abort_pre_m_req", bus.m_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_m_req", bus.m_req, 0);
    chk("abort_busy", bus.busy, 0);
    bus.d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("abort_no_ack", bus.d_ack, 0);
    end
    reset = 1'b1;
    cyc();
    chk("abort_after_ack", bus.d_ack, 0);
    chk("abort_after_busy", bus.busy, 0);
    chk("abort_mem_kept", mem[8'h60], 16'h0BAD);
    $display("txn abort: store to 0x0060 abandoned by reset");
    v = '{1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h0000, 0, 16'h0BAD, 16'h0000, 16'h0BAD};
    run_txn(v, "post_abort");

    // Random traffic against a transaction-level model
    reset_dut();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    spur = 1;
    last_d = 1'b0;
    in_txn = 1'b0;
    g_d = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    exp_if = '0;
    exp_d = '0;
    mreq_cnt = 0; txn_wait = 0; stall = 0; ntx = 0;
    for (int c = 0; c < 3000; c++) begin
      pf = bus.if_req;
      pd = bus.d_req;
      if (bus.m_req !== 1'b1) wait_cfg = $urandom_range(0, 3);
      cyc();
      ack_now = bus.if_ack || bus.d_ack;
      chk("rnd_ack_excl", bus.if_ack & bus.d_ack, 0);
      if (bus.m_req === 1'b1 && !in_txn) begin
        chk("rnd_grant_valid", pf || pd, 1);
        g_d = pd && (!pf || !last_d);
        last_d = g_d;
        in_txn = 1'b1;
        mreq_cnt = 0;
        txn_wait = wait_cfg;
        g_addr = g_d ? bus.d_addr : bus.if_addr;
        g_we = g_d ? bus.d_we : 1'b0;
        g_wdata = bus.d_wdata;
      end
      if (bus.m_req === 1'b1) begin
        mreq_cnt++;
        chk("rnd_m_addr", bus.m_addr, g_addr);
        chk("rnd_m_we", bus.m_we, g_we);
        if (g_we) chk("rnd_m_wdata", bus.m_wdata, g_wdata);
      end
      if (ack_now) begin
        chk("rnd_ack_in_txn", in_txn, 1);
        chk("rnd_ack_port", bus.d_ack, g_d);
        chk("rnd_wait_cycles", mreq_cnt, txn_wait + 1);
        if (!g_d) exp_if = ref_mem[g_addr[7:0]];
        else if (!g_we) exp_d = ref_mem[g_addr[7:0]];
        else ref_mem[g_addr[7:0]] = g_wdata;
        ntx++;
        $display("txn rnd%0d: %s addr=0x%04h we=%0d waits=%0d", ntx,
                 g_d ? "data" : "fetch", g_addr, g_we, txn_wait);
        in_txn = 1'b0;
        if (bus.if_ack) bus.if_req = 1'b0;
        else bus.d_req = 1'b0;
      end
      chk("rnd_busy", bus.busy, in_txn || ack_now);
      chk("rnd_if_rdata", bus.if_rdata, exp_if);
      chk("rnd_d_rdata", bus.d_rdata, exp_d);
      if ((bus.if_req || bus.d_req || in_txn) && !ack_now) stall++;
      else stall = 0;
      if (stall > 20) begin
        chk("rnd_watchdog", stall, 0);
        break;
      end
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 16'($urandom);
      end
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom);
        bus.d_addr = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
    end
    chk("rnd_progress", ntx > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memarb.md
# memarb

Single-port memory arbiter and sequencer for the 16-bit CPU. It lets the instruction-fetch path (driven by the datapath `pc`) and the load/store path (driven by `aluout`/`writedata`/`readdata`) share one unified memory port. It accepts one request at a time and drives a request/ready handshake to memory. Each requester gets a one-cycle acknowledge plus registered read data. Arbitration prevents either side from starving the other.

## Interface
Parameters:
- `n`, 16, data and address width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. `reset`=0 forces reset state immediately, independent of `clk`.
- `if_req`  in  1  fetch request; held high with `if_addr` stable until `if_ack`.
- `if_addr`  in  n  fetch address (word address).
- `if_ack`  out  1  one-cycle fetch-complete pulse.
- `if_rdata`  out  n  registered fetched instruction.
- `d_req`  in  1  data request; held high with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  n  data address.
- `d_wdata`  in  n  store data.
- `d_ack`  out  1  one-cycle data-complete pulse.
- `d_rdata`  out  n  registered load data.
- `m_req`  out  1  memory request, held until `m_ready`.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  n  memory address.
- `m_wdata`  out  n  memory write data.
- `m_rdata`  in  n  memory read data, valid when `m_ready`=1.
- `m_ready`  in  1  memory completion, sampled only while `m_req`=1.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, BUSY_I, BUSY_D, RESP. A one-bit `last_d` flag records whether the last grant went to data.
- **IDLE:** requests are sampled here only.
  - Only `if_req`: latch `if_addr`, set `m_we`=0, go to BUSY_I.
  - Only `d_req`: latch `d_addr`/`d_we`/`d_wdata`, go to BUSY_D.
  - Both high:
    - `last_d`=0: data wins.
    - `last_d`=1: fetch wins.
  - A grant sets `last_d` to 1 for data and 0 for fetch.
  - Neither high: stay in IDLE.
- **BUSY_I / BUSY_D:**
  - `m_req`=1; `m_addr`/`m_we`/`m_wdata` come from the latched registers and stay stable for the whole state.
  - While `m_ready`=0, remain in the state (unbounded wait states).
  - When `m_ready`=1:
    - BUSY_I captures `m_rdata` into `if_rdata`.
    - BUSY_D with a load captures `m_rdata` into `d_rdata`.
    - BUSY_D with a store leaves `d_rdata` unchanged.
  - In all cases the next state is RESP.
- **RESP:**
  - Exactly one of `if_ack`/`d_ack` is 1, matching the granted port.
  - `m_req`=0 and requests are ignored.
  - Always return to IDLE on the next edge.
- Requester rule: a `req` still high in the cycle after its ack is treated as a new request.
- `m_ready` outside BUSY states is ignored.
- The latched address and data registers ignore requester input changes while in BUSY.

## Timing
- **Reset values:**
  - State: IDLE; `last_d`=0.
  - `if_ack`, `d_ack`, `m_req`, `m_we`, `busy`: 0.
  - `m_addr`, `m_wdata`, `if_rdata`, `d_rdata`: 0.
- All outputs are registered or decoded purely from state. There is no combinational path from any input to any output.
- **Latency:** request sampled at edge E0 (IDLE to BUSY), so `m_req`=1 in cycle 1.
  - With `m_ready`=1 in cycle 1: edge E1 enters RESP, and ack and rdata are visible in cycle 2.
  - Total is 3 cycles for a zero-wait transaction, plus k cycles for k memory wait states.
  - Back-to-back throughput is one transaction per 3 cycles at zero wait.
- **Reset mid-transaction:** the FSM aborts immediately to IDLE and `m_req` drops asynchronously. The memory operation is abandoned and no ack is issued.
- `busy`=1 in BUSY_I, BUSY_D and RESP.

## Test plan
- **Single fetch, zero wait:** `if_req`=1 with `if_addr`=0x0004, memory returns 0x1234 with `m_ready`=1 on the first `m_req` cycle -> `m_addr`=0x0004 and `m_we`=0 in cycle 1; `if_ack`=1 and `if_rdata`=0x1234 in cycle 2; IDLE in cycle 3.
- **Load with 2 wait states:** `d_req`=1, `d_we`=0, `d_addr`=0x0010, `m_ready` high on the 3rd `m_req` cycle with data 0xBEEF -> `m_req` high for 3 cycles; `d_ack`=1 and `d_rdata`=0xBEEF one cycle later; `if_rdata` unchanged.
- **Store, then check held data:** load 0x00AA, then store to 0x0020 with `d_wdata`=0x5555 -> `m_we`=1 and `m_wdata`=0x5555 during BUSY_D; `d_ack` pulses; `d_rdata` stays 0x00AA.
- **Simultaneous requests, both held:**
  - Requirement: grant order data, fetch, data, fetch; `last_d` toggles each grant; no two consecutive grants to the same port.
  - Requirement: each ack fires exactly once per transaction.
- **Reset mid-BUSY:** assert `reset`=0 between edges during BUSY_D -> `m_req` and `busy` go 0 without a clock edge; no `d_ack`; after release, a fresh `if_req` is served normally.
- **Spurious ready:** `m_ready`=1 while IDLE or RESP -> no state change, no ack, and `if_rdata`/`d_rdata` unchanged.
